// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector for a PAT_LEN-bit pattern, MSB first.
// The state is the matched-prefix length (Depth). The next-depth and full-match
// lookups are built from PATTERN at elaboration. At run time each sample is one
// table lookup indexed by {Depth, A}.
module seq_detect_fsm #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    localparam int                DW      = $clog2(PAT_LEN + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clr,
    input  logic             En,
    input  logic             A,
    output logic             Match,
    output logic             Busy,
    output logic [DW-1:0]    Depth,
    output logic [CNT_W-1:0] Count
);

    // One table entry per {depth, bit} pair. Entries with depth >= PAT_LEN are
    // never reached, and their value is 0.
    localparam int TBL_N = 2 ** (DW + 1);

    typedef logic [TBL_N-1:0][DW-1:0] nxt_t;
    typedef logic [TBL_N-1:0]         full_t;

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
            $error("seq_detect_fsm: PAT_LEN must be in 2..16");
        end
    endgenerate

    // Next depth for every (depth, sample) pair. On a match the depth advances.
    // A full match wraps to the border length L, or to 0 when OVERLAP=0.
    // A mismatch falls back to the longest pattern prefix that is a suffix of
    // the bits seen so far.
    function automatic nxt_t build_nxt();
        nxt_t        t;
        logic [15:0] p;
        logic [16:0] s;
        logic        ok;
        logic        bb;
        int          l;
        int          v;
        t = '0;
        p = '0;
        for (int i = 0; i < PAT_LEN; i++) p[i] = PATTERN[PAT_LEN-1-i];
        l = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) if (p[j] != p[PAT_LEN-k+j]) ok = 1'b0;
            if (ok) l = k;
        end
        for (int d = 0; d < PAT_LEN; d++) begin
            for (int b = 0; b < 2; b++) begin
                bb = (b != 0);
                if (bb == p[d]) begin
                    v = (d + 1 < PAT_LEN) ? d + 1 : (OVERLAP ? l : 0);
                end else begin
                    s = '0;
                    for (int i = 0; i < d; i++) s[i] = p[i];
                    s[d] = bb;
                    v = 0;
                    for (int k = 1; k <= d; k++) begin
                        ok = 1'b1;
                        for (int j = 0; j < k; j++) if (s[d+1-k+j] != p[j]) ok = 1'b0;
                        if (ok) v = k;
                    end
                end
                t[2*d+b] = v[DW-1:0];
            end
        end
        return t;
    endfunction

    // Only one pair completes the pattern: the last depth together with the last pattern bit.
    function automatic full_t build_full();
        full_t t;
        t = '0;
        t[2*(PAT_LEN-1) + (PATTERN[0] ? 1 : 0)] = 1'b1;
        return t;
    endfunction

    localparam nxt_t  NXT  = build_nxt();
    localparam full_t FULL = build_full();

    logic [DW:0] idx;
    assign idx  = {Depth, A};
    assign Busy = (Depth != '0);

    // Depth/match/count register. Reset has the highest priority, then Clr, then En.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Depth <= '0;
            Count <= '0;
            Match <= 1'b0;
        end else if (Clr) begin
            Depth <= '0;
            Count <= '0;
            Match <= 1'b0;
        end else if (En) begin
            Depth <= NXT[idx];
            Match <= FULL[idx];
            if (FULL[idx] && (Count != '1)) Count <= Count + 1'b1;
        end else begin
            Match <= 1'b0;
        end
    end

endmodule
